// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered active-low syncs,
// blank-gated colour and the end-of-visible-frame qualifiers for frame capture.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        I_25MHZ_CLK,
    input  logic        I_RESET_N,
    input  logic        I_RED,
    input  logic        I_GREEN,
    input  logic        I_BLUE,
    output logic [9:0]  O_H_CNT,
    output logic [9:0]  O_V_CNT,
    output logic        O_RED,
    output logic        O_GREEN,
    output logic        O_BLUE,
    output logic        O_HSYNC,
    output logic        O_VSYNC,
    output logic        O_DISPLAY_DATA,
    output logic        O_DRAW_FINISH,
    output logic [15:0] O_FRAME_CNT
);

    // Both totals must fit the 10-bit counters (<= 1024); larger rasters are unsupported.
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_red;
    logic        r_green;
    logic        r_blue;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_display_data;
    logic        r_draw_finish;
    logic [15:0] r_frame_cnt;

    logic w_h_last;
    logic w_v_last;
    logic w_vis;
    logic w_hsync_on;
    logic w_vsync_on;
    logic w_draw_finish;

    assign w_h_last      = (r_h_cnt == H_LAST);
    assign w_v_last      = (r_v_cnt == V_LAST);
    assign w_vis         = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hsync_on    = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    // Vertical sync is a whole-line decision, so it ignores the horizontal position.
    assign w_vsync_on    = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    assign w_draw_finish = (r_h_cnt == H_VIS) && (r_v_cnt == V_VIS_LAST);

    // NOTE: state is updated with <= so every flop samples the pre-edge counter values.
    always_ff @(posedge I_25MHZ_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    always_ff @(posedge I_25MHZ_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_red          <= 1'b0;
            r_green        <= 1'b0;
            r_blue         <= 1'b0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_display_data <= 1'b0;
            r_draw_finish  <= 1'b0;
        end else begin
            r_red          <= I_RED & w_vis;
            r_green        <= I_GREEN & w_vis;
            r_blue         <= I_BLUE & w_vis;
            r_hsync        <= ~w_hsync_on;
            r_vsync        <= ~w_vsync_on;
            r_display_data <= w_vis;
            r_draw_finish  <= w_draw_finish;
        end
    end

    // Counts on the same edge that raises the draw-finish pulse; wraps naturally.
    always_ff @(posedge I_25MHZ_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_frame_cnt <= '0;
        end else if (w_draw_finish) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign O_H_CNT        = r_h_cnt;
    assign O_V_CNT        = r_v_cnt;
    assign O_RED          = r_red;
    assign O_GREEN        = r_green;
    assign O_BLUE         = r_blue;
    assign O_HSYNC        = r_hsync;
    assign O_VSYNC        = r_vsync;
    assign O_DISPLAY_DATA = r_display_data;
    assign O_DRAW_FINISH  = r_draw_finish;
    assign O_FRAME_CNT    = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line timing and colour gating, plus a reduced raster
// for frame-level timing, draw-finish placement and mid-frame reset recovery.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Full-size instance
    logic        rst_n;
    logic        in_red;
    logic        in_blue;
    logic        green_mode;
    logic        in_green;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        red;
    logic        green;
    logic        blue;
    logic        hs;
    logic        vs;
    logic        dd;
    logic        df;
    logic [15:0] fc;

    assign in_green = green_mode ? h_cnt[0] : 1'b1;

    vga_timing_gen dut (
        .I_25MHZ_CLK    (clk),
        .I_RESET_N      (rst_n),
        .I_RED          (in_red),
        .I_GREEN        (in_green),
        .I_BLUE         (in_blue),
        .O_H_CNT        (h_cnt),
        .O_V_CNT        (v_cnt),
        .O_RED          (red),
        .O_GREEN        (green),
        .O_BLUE         (blue),
        .O_HSYNC        (hs),
        .O_VSYNC        (vs),
        .O_DISPLAY_DATA (dd),
        .O_DRAW_FINISH  (df),
        .O_FRAME_CNT    (fc)
    );

    // Reduced raster: line 14, frame 98
    logic        rst_s_n;
    logic        s_in_green;
    logic [9:0]  s_h_cnt;
    logic [9:0]  s_v_cnt;
    logic        s_red;
    logic        s_green;
    logic        s_blue;
    logic        s_hs;
    logic        s_vs;
    logic        s_dd;
    logic        s_df;
    logic [15:0] s_fc;

    assign s_in_green = s_h_cnt[0];

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) dut_s (
        .I_25MHZ_CLK    (clk),
        .I_RESET_N      (rst_s_n),
        .I_RED          (1'b1),
        .I_GREEN        (s_in_green),
        .I_BLUE         (1'b0),
        .O_H_CNT        (s_h_cnt),
        .O_V_CNT        (s_v_cnt),
        .O_RED          (s_red),
        .O_GREEN        (s_green),
        .O_BLUE         (s_blue),
        .O_HSYNC        (s_hs),
        .O_VSYNC        (s_vs),
        .O_DISPLAY_DATA (s_dd),
        .O_DRAW_FINISH  (s_df),
        .O_FRAME_CNT    (s_fc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int   cyc;
        int   last_rise;
        int   t_hfall;
        int   t_vfall;
        int   mh;
        int   mv;
        int   ph;
        int   pv;
        int   n;
        int   dd_count;
        int   last_df;
        logic e_dd;
        logic p_dd;
        logic p_hs;
        logic p_vs;

        rst_n      = 1'b0;
        rst_s_n    = 1'b0;
        in_red     = 1'b1;
        in_blue    = 1'b1;
        green_mode = 1'b0;

        // Reset values with all colour inputs high
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_hsync", 32'(hs), 1);
        check("rst_vsync", 32'(vs), 1);
        check("rst_dd", 32'(dd), 0);
        check("rst_df", 32'(df), 0);
        check("rst_rgb", 32'({red, green, blue}), 0);
        check("rst_fc", 32'(fc), 0);
        check("rst_h", 32'(h_cnt), 0);
        check("rst_v", 32'(v_cnt), 0);

        // E1 presents pixel (0,0) and moves the counter to (1,0)
        rst_n = 1'b1;
        @(negedge clk);
        check("e1_dd", 32'(dd), 1);
        check("e1_red", 32'(red), 1);
        check("e1_green", 32'(green), 1);
        check("e1_blue", 32'(blue), 1);
        check("e1_h", 32'(h_cnt), 1);
        check("e1_v", 32'(v_cnt), 0);

        // Three full lines: colour gating and horizontal timing
        green_mode = 1'b1;
        in_blue    = 1'b0;
        mh = 0; mv = 0; cyc = 1; last_rise = 1; t_hfall = 0;
        p_dd = 1'b1; p_hs = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            cyc++;
            mh++;
            if (mh == 800) begin
                mh = 0;
                mv++;
            end
            e_dd = (mh < 640) && (mv < 480);
            check("red_gate", 32'(red), 32'(e_dd));
            check("green_alt", 32'(green), 32'(e_dd && (mh % 2 == 1)));
            check("blue_zero", 32'(blue), 0);
            check("hsync_lvl", 32'(hs), 32'(!(mh >= 656 && mh <= 751)));
            check("vsync_idle", 32'(vs), 1);
            check("df_idle", 32'(df), 0);
            if (dd && !p_dd) begin
                check("line_period", cyc - last_rise, 800);
                last_rise = cyc;
            end
            if (!dd && p_dd) check("dd_run", cyc - last_rise, 640);
            if (!hs && p_hs) begin
                check("hs_fall_ofs", cyc - last_rise, 656);
                t_hfall = cyc;
            end
            if (hs && !p_hs) check("hs_low", cyc - t_hfall, 96);
            p_dd = dd;
            p_hs = hs;
        end
        check("line3_h", 32'(h_cnt), 1);
        check("line3_v", 32'(v_cnt), 3);
        check("line3_fc", 32'(fc), 0);

        // Mid-line reset is asynchronous and restarts at (0,0)
        n = 0;
        while (h_cnt != 10'd300 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_h300", 32'(h_cnt), 300);
        rst_n = 1'b0;
        #1;
        check("async_h", 32'(h_cnt), 0);
        check("async_v", 32'(v_cnt), 0);
        check("async_dd", 32'(dd), 0);
        check("async_sync", 32'({hs, vs}), 3);
        check("async_rgb", 32'({red, green, blue}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_dd", 32'(dd), 1);
        check("rel_red", 32'(red), 1);
        check("rel_green", 32'(green), 0);
        check("rel_h", 32'(h_cnt), 1);
        check("rel_v", 32'(v_cnt), 0);

        // Reduced raster: two frames and a bit, pixel-exact model
        rst_s_n = 1'b1;
        p_dd = 1'b0; p_hs = 1'b1; p_vs = 1'b1;
        dd_count = 0; last_df = 0; t_hfall = 0; t_vfall = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            ph = (k - 1) % 14;
            pv = ((k - 1) % 98) / 14;
            e_dd = (ph < 8) && (pv < 4);
            check("s_dd", 32'(s_dd), 32'(e_dd));
            check("s_red", 32'(s_red), 32'(e_dd));
            check("s_green", 32'(s_green), 32'(e_dd && (ph % 2 == 1)));
            check("s_blue", 32'(s_blue), 0);
            check("s_hsync", 32'(s_hs), 32'(!(ph == 10 || ph == 11)));
            check("s_vsync", 32'(s_vs), 32'(pv != 5));
            check("s_df", 32'(s_df), 32'(ph == 8 && pv == 3));
            if (s_df) begin
                check("s_df_dd_count", dd_count, 32);
                check("s_df_after_dd", 32'({p_dd, s_dd}), 2);
                if (last_df == 0) check("s_df_first", k, 51);
                else              check("s_df_period", k - last_df, 98);
                last_df  = k;
                dd_count = 0;
            end
            if (s_dd) dd_count++;
            if (!s_hs && p_hs) begin
                check("s_hs_fall", (k - 1) % 14, 10);
                t_hfall = k;
            end
            if (s_hs && !p_hs) check("s_hs_low", k - t_hfall, 2);
            if (!s_vs && p_vs) begin
                check("s_vs_fall", (k - 1) % 98, 70);
                t_vfall = k;
            end
            if (s_vs && !p_vs) check("s_vs_low", k - t_vfall, 14);
            p_dd = s_dd;
            p_hs = s_hs;
            p_vs = s_vs;
        end
        check("s_fc_two", 32'(s_fc), 2);

        // Reduced raster: reset mid-frame before the draw-finish point
        n = 0;
        while (!(s_v_cnt == 10'd2 && s_h_cnt == 10'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("s_reach_2_3", 32'({s_v_cnt, s_h_cnt}), 32'({10'd2, 10'd3}));
        rst_s_n = 1'b0;
        #1;
        check("s_rst_h", 32'(s_h_cnt), 0);
        check("s_rst_fc", 32'(s_fc), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s_rst_no_df", 32'(s_df), 0);
        end
        rst_s_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_df && n < 200);
        check("s_df_latency", n, 51);
        check("s_fc_one", 32'(s_fc), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
